// File: rtl/ram_byte_sync.sv
// ram_byte_sync: byte-addressed data RAM with byte/halfword/word big-endian
// accesses, a request/done handshake, programmable wait states, wrap-around
// addressing and an optional alignment fault.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   enable     request strobe, sampled only in IDLE
//   readWrite  1 = read, 0 = write
//   address    byte address of the most-significant byte
//   dataIn     write data, right-justified
//   MAS        access size: 00 byte, 01 halfword, 10 word, 11 undefined
//   dataOut    read data, right-justified, zero-extended, held between reads
//   done       one-cycle completion pulse
//   busy       high from acceptance through the done cycle
//   fault      valid with done; request rejected, no memory effect
//
// state  | meaning
// IDLE   | waiting for enable
// WAIT   | wait-state countdown
// ACCESS | memory read/write happens at the edge leaving this state
// DONE   | done pulse, fault reported, back to IDLE

module ram_byte_sync #(
    parameter int ADDR_W      = 9,
    parameter int WAIT_STATES = 2,
    parameter bit ALIGN_CHECK = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              readWrite,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       dataIn,
    input  logic [1:0]        MAS,
    output logic [31:0]       dataOut,
    output logic              done,
    output logic              busy,
    output logic              fault
);

    localparam int         DEPTH   = 2 ** ADDR_W;
    localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;

    state_t            state_q;
    state_t            state_d;
    logic [3:0]        cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic              rw_q;
    logic [1:0]        mas_q;
    logic [31:0]       din_q;
    logic              fault_q;
    logic              fault_req;

    logic [7:0]        mem [0:DEPTH-1];

    logic [ADDR_W-1:0] a0, a1, a2, a3;
    logic [31:0]       rd_data;

    always_comb begin
        fault_req = (MAS == 2'b11);
        if (ALIGN_CHECK) begin
            if (MAS == 2'b01 && address[0])
                fault_req = 1'b1;
            if (MAS == 2'b10 && address[1:0] != 2'b00)
                fault_req = 1'b1;
        end
    end

    // Byte offsets wrap naturally at the top of memory.
    assign a0 = addr_q;
    assign a1 = addr_q + ADDR_W'(1);
    assign a2 = addr_q + ADDR_W'(2);
    assign a3 = addr_q + ADDR_W'(3);

    always_comb begin
        rd_data = '0;
        case (mas_q)
            2'b00:   rd_data = {24'b0, mem[a0]};
            2'b01:   rd_data = {16'b0, mem[a0], mem[a1]};
            2'b10:   rd_data = {mem[a0], mem[a1], mem[a2], mem[a3]};
            default: rd_data = '0;
        endcase
    end

    // State register plus the request latch, wait counter and read data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            rw_q    <= 1'b0;
            mas_q   <= '0;
            din_q   <= '0;
            fault_q <= 1'b0;
            dataOut <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && enable) begin
                addr_q  <= address;
                rw_q    <= readWrite;
                mas_q   <= MAS;
                din_q   <= dataIn;
                fault_q <= fault_req;
                cnt_q   <= WS_LOAD;
            end else if (state_q == S_WAIT && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (state_q == S_ACCESS && rw_q && !fault_q)
                dataOut <= rd_data;
        end
    end

    // Storage is never reset; reset holds the FSM in IDLE so no write fires.
    always_ff @(posedge clk) begin
        if (state_q == S_ACCESS && !rw_q && !fault_q) begin
            case (mas_q)
                2'b00: mem[a0] <= din_q[7:0];
                2'b01: begin
                    mem[a0] <= din_q[15:8];
                    mem[a1] <= din_q[7:0];
                end
                2'b10: begin
                    mem[a0] <= din_q[31:24];
                    mem[a1] <= din_q[23:16];
                    mem[a2] <= din_q[15:8];
                    mem[a3] <= din_q[7:0];
                end
                default: ;
            endcase
        end
    end

    // WAIT lasts WAIT_STATES cycles, with a floor of one cycle: a load of
    // zero or one both leave after a single WAIT cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (enable) state_d = S_WAIT;
            S_WAIT:   if (cnt_q <= 4'd1) state_d = S_ACCESS;
            S_ACCESS: state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy  = (state_q != S_IDLE);
        done  = (state_q == S_DONE);
        fault = (state_q == S_DONE) && fault_q;
    end

endmodule

// File: tb/tb_ram_byte_sync.sv
module tb_ram_byte_sync;

    typedef struct packed {
        logic [31:0] data;
        logic        flt;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        en_a, en_b;
    logic        rw;
    logic [8:0]  addr;
    logic [31:0] din;
    logic [1:0]  mas;
    logic [31:0] dout_a, dout_b;
    logic        done_a, done_b, busy_a, busy_b, fault_a, fault_b;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    logic [31:0] last_a = '0;
    logic [31:0] last_b = '0;

    always #5 clk = ~clk;

    ram_byte_sync #(.ADDR_W(9), .WAIT_STATES(2), .ALIGN_CHECK(1'b0)) dut_a (
        .clk(clk), .reset(reset), .enable(en_a), .readWrite(rw), .address(addr),
        .dataIn(din), .MAS(mas), .dataOut(dout_a), .done(done_a), .busy(busy_a),
        .fault(fault_a)
    );

    ram_byte_sync #(.ADDR_W(9), .WAIT_STATES(2), .ALIGN_CHECK(1'b1)) dut_b (
        .clk(clk), .reset(reset), .enable(en_b), .readWrite(rw), .address(addr),
        .dataIn(din), .MAS(mas), .dataOut(dout_b), .done(done_b), .busy(busy_b),
        .fault(fault_b)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Scoreboard monitors: pop an expectation on every done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (done_a === 1'b1) begin
            if (q_a.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL sb_a unexpected done: got done=1 expected none");
            end else begin
                e = q_a.pop_front();
                check("sb_a dataOut", dout_a, e.data);
                check("sb_a fault", {31'b0, fault_a}, {31'b0, e.flt});
            end
        end
        if (done_b === 1'b1) begin
            if (q_b.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL sb_b unexpected done: got done=1 expected none");
            end else begin
                e = q_b.pop_front();
                check("sb_b dataOut", dout_b, e.data);
                check("sb_b fault", {31'b0, fault_b}, {31'b0, e.flt});
            end
        end
    end

    // Issue one request and wait for its completion. Inputs are scrambled
    // right after acceptance; the result must not depend on them.
    task automatic issue(input bit sel_b, input bit r, input logic [8:0] a,
                         input logic [1:0] m, input logic [31:0] d,
                         input logic [31:0] rd_exp, input bit f_exp, input bit timed);
        exp_t e;
        logic got;
        logic [4:0] dv, bv;
        @(negedge clk);
        rw = r; addr = a; mas = m; din = d;
        if (r && !f_exp) begin
            if (sel_b) last_b = rd_exp; else last_a = rd_exp;
        end
        e.data = sel_b ? last_b : last_a;
        e.flt  = f_exp;
        if (sel_b) begin q_b.push_back(e); en_b = 1'b1; end
        else       begin q_a.push_back(e); en_a = 1'b1; end
        @(posedge clk);
        #1;
        en_a = 1'b0; en_b = 1'b0;
        rw = ~r; addr = ~a; mas = ~m; din = ~d;
        if (timed) begin
            for (int k = 0; k < 5; k++) begin
                if (k > 0) @(posedge clk);
                @(negedge clk);
                dv[k] = done_a;
                bv[k] = busy_a;
            end
            check("done timing", {27'b0, dv}, 32'b01000);
            check("busy timing", {27'b0, bv}, 32'b01111);
        end else begin
            got = 1'b0;
            for (int i = 0; i < 12 && !got; i++) begin
                @(negedge clk);
                got = sel_b ? done_b : done_a;
            end
            if (!got) begin
                n_checks++; n_fail++;
                $display("FAIL done timeout: got no done expected done within 12 cycles");
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [14:0] dmask;
        int ndone;
        reset = 1'b1; en_a = 1'b0; en_b = 1'b0; rw = 1'b0;
        addr = '0; din = '0; mas = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset dataOut", dout_a, 32'h0);
        check("reset done", {31'b0, done_a}, 32'h0);
        check("reset busy", {31'b0, busy_a}, 32'h0);
        check("reset fault", {31'b0, fault_a}, 32'h0);

        // Word write / read with cycle-exact handshake timing.
        issue(0, 0, 9'h010, 2'b10, 32'hDEADBEEF, '0, 0, 1);
        issue(0, 1, 9'h010, 2'b10, '0, 32'hDEADBEEF, 0, 1);
        issue(0, 1, 9'h010, 2'b00, '0, 32'h000000DE, 0, 0);
        issue(0, 1, 9'h013, 2'b00, '0, 32'h000000EF, 0, 0);
        issue(0, 1, 9'h012, 2'b01, '0, 32'h0000BEEF, 0, 0);
        issue(0, 1, 9'h011, 2'b01, '0, 32'h0000ADBE, 0, 0);

        // Top-of-memory word wraps to bytes 0 and 1.
        issue(0, 0, 9'h1FE, 2'b10, 32'h11223344, '0, 0, 0);
        issue(0, 1, 9'h1FE, 2'b00, '0, 32'h00000011, 0, 0);
        issue(0, 1, 9'h1FF, 2'b00, '0, 32'h00000022, 0, 0);
        issue(0, 1, 9'h000, 2'b00, '0, 32'h00000033, 0, 0);
        issue(0, 1, 9'h001, 2'b00, '0, 32'h00000044, 0, 0);
        issue(0, 1, 9'h1FE, 2'b10, '0, 32'h11223344, 0, 0);

        // Narrow writes touch only their bytes.
        issue(0, 0, 9'h011, 2'b00, 32'h00000055, '0, 0, 0);
        issue(0, 1, 9'h010, 2'b10, '0, 32'hDE55BEEF, 0, 0);
        issue(0, 0, 9'h012, 2'b01, 32'h0000A1B2, '0, 0, 0);
        issue(0, 1, 9'h010, 2'b10, '0, 32'hDE55A1B2, 0, 0);

        // Undefined MAS faults with no memory effect.
        issue(0, 0, 9'h010, 2'b11, 32'hFFFFFFFF, '0, 1, 0);
        issue(0, 1, 9'h010, 2'b10, '0, 32'hDE55A1B2, 0, 0);

        // enable held high: one done every five cycles.
        @(negedge clk);
        rw = 1'b1; addr = 9'h010; mas = 2'b10; din = '0;
        for (int i = 0; i < 3; i++) q_a.push_back('{data: 32'hDE55A1B2, flt: 1'b0});
        en_a = 1'b1;
        dmask = '0;
        ndone = 0;
        for (int e = 0; e < 15; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (done_a) begin dmask[e] = 1'b1; ndone++; end
        end
        en_a = 1'b0;
        check("held enable done positions", {17'b0, dmask}, {17'b0, 15'b010000100001000});
        check("held enable done count", 32'(ndone), 32'd3);
        repeat (3) @(negedge clk);

        // Reset during WAIT of a write aborts it.
        issue(0, 0, 9'h040, 2'b10, 32'h01020304, '0, 0, 0);
        issue(0, 1, 9'h010, 2'b10, '0, 32'hDE55A1B2, 0, 0);
        @(negedge clk);
        rw = 1'b0; addr = 9'h040; mas = 2'b10; din = 32'hCAFEF00D;
        en_a = 1'b1;
        @(posedge clk);
        #1;
        en_a = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("async reset done", {31'b0, done_a}, 32'h0);
        check("async reset busy", {31'b0, busy_a}, 32'h0);
        check("async reset dataOut", dout_a, 32'h0);
        last_a = '0;
        last_b = '0;
        @(negedge clk);
        reset = 1'b0;
        issue(0, 1, 9'h040, 2'b10, '0, 32'h01020304, 0, 0);

        // Alignment checking instance.
        issue(1, 0, 9'h020, 2'b10, 32'hA5A5A5A5, '0, 0, 0);
        issue(1, 1, 9'h020, 2'b10, '0, 32'hA5A5A5A5, 0, 0);
        issue(1, 0, 9'h021, 2'b10, 32'h12345678, '0, 1, 0);
        issue(1, 0, 9'h021, 2'b01, 32'h00001234, '0, 1, 0);
        issue(1, 1, 9'h021, 2'b01, '0, '0, 1, 0);
        issue(1, 1, 9'h020, 2'b10, '0, 32'hA5A5A5A5, 0, 0);
        issue(1, 1, 9'h022, 2'b01, '0, 32'h0000A5A5, 0, 0);

        repeat (3) @(negedge clk);
        check("scoreboard a drained", 32'(q_a.size()), 32'd0);
        check("scoreboard b drained", 32'(q_b.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_byte_sync.md
Name: ram_byte_sync

Overview:
- Clocked, parametrised successor to the team's 512x8 byte-addressed data RAM. Serves byte, halfword and word accesses, big-endian, selected by MAS.
- Adds a request/done handshake, programmable wait states, wrap-around addressing and an optional alignment fault.
- Sits between the CPU memory-access stage and data storage. The access FSM stalls the pipeline until done.

Parameters:
- ADDR_W, 9, byte-address width; depth is 2**ADDR_W bytes.
- WAIT_STATES, 2, extra cycles inserted before the access completes; legal range 0..15.
- ALIGN_CHECK, 0, when 1, misaligned halfword/word requests fault instead of executing.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  request strobe; sampled only in IDLE
- readWrite  in  1  1 = read, 0 = write
- address  in  ADDR_W  byte address of most-significant byte
- dataIn  in  32  write data, right-justified (byte in [7:0], half in [15:0])
- MAS  in  2  00 byte, 01 halfword, 10 word, 11 undefined
- dataOut  out  32  read data, right-justified, zero-extended
- done  out  1  one-cycle completion pulse
- busy  out  1  high from acceptance until the done cycle inclusive
- fault  out  1  valid with done; 1 = request rejected, no memory effect

Behaviour:
- Reset (async, active-high) sets FSM to IDLE and clears dataOut, done, busy, fault and the wait counter to 0. Memory contents are not cleared. Reset mid-access aborts the access; a write aborted before its ACCESS edge leaves memory unchanged.
- FSM states and transitions:
  - IDLE -> WAIT when enable=1. On that edge, latch address, readWrite, MAS and dataIn, load counter=WAIT_STATES, set busy=1. Inputs are ignored after acceptance.
  - WAIT: counter decrements each cycle; -> ACCESS when counter==0. With WAIT_STATES=0, WAIT lasts exactly one cycle.
  - ACCESS: perform the access at the edge, -> DONE.
  - DONE: done=1 and busy=1 for one cycle, -> IDLE. enable is not accepted in DONE.
- Latency:
  - Request accepted at edge 0; done is high during cycle WAIT_STATES+2 after acceptance.
  - Back-to-back requests: minimum spacing is WAIT_STATES+3 cycles.
- Fault: evaluated at acceptance, reported in DONE with identical timing. A faulted request performs no memory write and leaves dataOut unchanged. Fault conditions:
  - MAS=11.
  - ALIGN_CHECK=1 and MAS=01 with address[0]=1.
  - ALIGN_CHECK=1 and MAS=10 with address[1:0]!=0.
- Byte order: big-endian. Byte at address A is most significant.
  - Halfword = {mem[A], mem[A+1]}.
  - Word = {mem[A], mem[A+1], mem[A+2], mem[A+3]}.
- Address arithmetic: A+k is computed modulo 2**ADDR_W, so the top-of-memory access wraps to byte 0. With ALIGN_CHECK=0, misaligned accesses execute with wrap.
- Reads: dataOut is updated at the ACCESS edge and held until the next successful read or reset.
  - Byte: {24'b0, mem[A]}.
  - Halfword: {16'b0, mem[A], mem[A+1]}.
- Writes: affect only the addressed bytes. dataOut is unchanged by writes.
- dataOut is never tri-stated.
- done and fault are 0 in every state except DONE.

Test Plan:
- Reset, then word write 32'hDEADBEEF at 0x010 and word read at 0x010 -> dataOut=32'hDEADBEEF, fault=0. With WAIT_STATES=2, done is high exactly 4 cycles after the accepting edge; busy is high for cycles 1-4.
- Byte read at 0x010 -> 32'h000000DE. Byte read at 0x013 -> 32'h000000EF. Halfword read at 0x012 (aligned) -> 32'h0000BEEF.
- Word write 32'h11223344 at 0x1FE with ALIGN_CHECK=0 -> mem[0x1FE]=11, mem[0x1FF]=22, mem[0x000]=33, mem[0x001]=44. Reading the same word returns 32'h11223344.
- MAS=11 write, and (ALIGN_CHECK=1) a word write at 0x021 -> done with fault=1, memory unchanged, dataOut holds its previous value.
- enable held high through a whole access -> exactly one done per WAIT_STATES+3 cycles. Changing address/dataIn while busy has no effect on the result.
- Assert reset during WAIT of a word write to 0x040 -> done, busy and dataOut are 0 immediately (before the next edge). A later read at 0x040 returns the pre-write contents.
